int_regfile_scb: RTL and testbench
==================================

// Module: int_regfile_scb
// PURPOSE
//  Parametrised integer register file with NUM_RD combinational read ports and one write port.
//  Write-to-read bypass is internal. An integrated scoreboard keeps one busy bit per register.
//  The decode stage allocates a destination (sets busy), writeback clears it, and busy is reported per read port.
//  Sits between decode (reads/alloc) and writeback (write); replaces the plain 32x32 file.
// PARAMETERS
//  XLEN     32  data width in bits
//  NREGS    32  number of architectural registers (power of 2, >=2)
//  AW       5   address width, = $clog2(NREGS)
//  NUM_RD   2   number of read ports (1..4)
//  ZERO_REG 1   1: register 0 hardwired to zero (never written, never busy); 0: ordinary register
// PORTS
//  clk_i        in   1           clock, all state updates on rising edge
//  rsn_i        in   1           reset, asynchronous, active-low
//  rd_addr_i    in   NUM_RD*AW   read addresses, port p at [p*AW +: AW]
//  rd_data_o    out  NUM_RD*XLEN read data, port p at [p*XLEN +: XLEN]
//  rd_busy_o    out  NUM_RD      1 = operand of port p has a pending (unwritten) producer
//  wr_en_i      in   1           write strobe
//  wr_addr_i    in   AW          write address
//  wr_data_i    in   XLEN        write data
//  alloc_en_i   in   1           mark alloc_addr_i busy (instruction issued with this destination)
//  alloc_addr_i in   AW          destination being allocated
//  flush_i      in   1           clear all busy bits (pipeline flush)
//  busy_cnt_o   out  AW+1        number of busy bits currently set
// BEHAVIOUR
//  Reset (rsn_i low, async): all registers = 0, all busy = 0, busy_cnt_o = 0, so rd_data_o = 0 and rd_busy_o = 0.
//  Read path (combinational, 0 latency), per port p with address a:
//   - ZERO_REG=1 and a==0: data = 0, busy = 0.
//   - else if wr_en_i and wr_addr_i==a: data = wr_data_i (bypass), busy = 0.
//   - else: data = regs[a], busy = busy[a].
//   - Bypass of an x0 write never happens when ZERO_REG=1.
//  Write (rising edge): if wr_en_i and not (ZERO_REG and wr_addr_i==0), regs[wr_addr_i] <= wr_data_i.
//   - A write to a non-busy register is legal: data is updated and busy stays 0.
//  Busy-bit update at the rising edge, priority high to low, evaluated per register r:
//   1. flush_i: busy[r] <= 0 for all r. The alloc in the same cycle is dropped. The write in the same cycle still updates data.
//   2. alloc_en_i and alloc_addr_i==r (r legal, not x0 when ZERO_REG): busy[r] <= 1.
//      Alloc wins over a same-cycle write to r, because the new producer supersedes the old one.
//   3. wr_en_i and wr_addr_i==r: busy[r] <= 0.
//   4. otherwise hold.
//  Alloc of an already-busy register: it stays busy. There is no counting; one writeback clears it.
//  busy_cnt_o: registered popcount of busy bits, updated on the same edge as the busy bits. Range 0..NREGS (no overflow with AW+1 bits).
//  Reset asserted mid-operation: state clears immediately. The first edge after release behaves as from reset.
//  Multiple read ports may use the same address; each port is independent.
//  Address width is exact. No out-of-range addresses exist since NREGS = 2**AW.
// TESTING
//  1. Reset, then read all ports at addresses 0..31 -> rd_data_o = 0, rd_busy_o = 0, busy_cnt_o = 0.
//  2. Write x5 = 32'hDEAD_BEEF. Next cycle read x5 on both ports -> 32'hDEAD_BEEF, busy 0.
//     In the write cycle itself the port reads 32'hDEAD_BEEF via bypass.
//  3. Write x0 = 32'h1234 (ZERO_REG=1), then read x0 -> 0. Alloc x0 -> busy_cnt_o stays 0.
//  4. Alloc x7 -> next cycle rd_busy_o=1 for x7 and busy_cnt_o=1.
//     Write x7 = 32'h55 -> same cycle busy=0 with data 32'h55 (bypass); next cycle busy_cnt_o=0.
//  5. Busy x3, then in one cycle alloc x3 and write x3 = 32'hA5 -> next cycle data 32'hA5, busy=1, busy_cnt_o=1.
//  6. Alloc x1, x2, x3 over three cycles (busy_cnt_o=3). Flush together with alloc x4 -> next cycle all busy 0, busy_cnt_o=0.
//     Then assert rsn_i low mid-cycle after writing x9 -> x9 reads 0 immediately.

Source files
------------

// File: rtl/int_regfile_scb.sv
// Integer register file with NUM_RD combinational read ports, one write port,
// write-to-read bypass and a per-register busy scoreboard with a registered popcount.
module int_regfile_scb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rsn_i,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [XLEN-1:0]          wr_data_i,
  input  logic                     alloc_en_i,
  input  logic [AW-1:0]            alloc_addr_i,
  input  logic                     flush_i,
  output logic [AW:0]              busy_cnt_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic [AW-1:0]    rd_addr [NUM_RD];
  logic             wr_ok, alloc_ok;

  assign wr_ok    = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == '0));
  assign alloc_ok = alloc_en_i && !flush_i && !((ZERO_REG != 0) && (alloc_addr_i == '0));

  // Alloc is applied after the write clear so a new producer supersedes the old one.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wr_ok)    busy_d[wr_addr_i]    = 1'b0;
      if (alloc_ok) busy_d[alloc_addr_i] = 1'b1;
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_addr[p] = rd_addr_i[p*AW +: AW];
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_data_o[p*XLEN +: XLEN] = '0;
        rd_busy_o[p]              = 1'b0;
      end else if (wr_en_i && (wr_addr_i == rd_addr[p])) begin
        rd_data_o[p*XLEN +: XLEN] = wr_data_i;
        rd_busy_o[p]              = 1'b0;
      end else begin
        rd_data_o[p*XLEN +: XLEN] = regs_q[rd_addr[p]];
        rd_busy_o[p]              = busy_q[rd_addr[p]];
      end
    end
  end

  assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_int_regfile_scb.sv
// Self-checking bench for int_regfile_scb: directed vector table, reset sequences
// and a randomized phase checked against an array-based reference model.
module tb_int_regfile_scb;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned NUM_RD = 2;

  logic                   clk_i = 1'b0;
  logic                   rsn_i;
  logic [NUM_RD*AW-1:0]   rd_addr_i;
  logic [NUM_RD*XLEN-1:0] rd_data_o;
  logic [NUM_RD-1:0]      rd_busy_o;
  logic                   wr_en_i;
  logic [AW-1:0]          wr_addr_i;
  logic [XLEN-1:0]        wr_data_i;
  logic                   alloc_en_i;
  logic [AW-1:0]          alloc_addr_i;
  logic                   flush_i;
  logic [AW:0]            busy_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  int_regfile_scb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_busy_o(rd_busy_o), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .alloc_en_i(alloc_en_i), .alloc_addr_i(alloc_addr_i), .flush_i(flush_i),
    .busy_cnt_o(busy_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ae;
    logic [4:0]  aa;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    int          cnt;
  } vec_t;

  vec_t tbl [15];

  // Reference state: architectural values and pending-producer flags.
  logic [31:0] mregs [NREGS];
  logic        mbusy [NREGS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ae, input logic [4:0] aa, input logic fl,
                       input logic [4:0] r0, input logic [4:0] r1);
    wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    alloc_en_i = ae; alloc_addr_i = aa; flush_i = fl;
    rd_addr_i = {r1, r0};
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic b);
    if (a == 0) begin
      d = '0; b = 1'b0;
    end else if (wr_en_i && wr_addr_i == a) begin
      d = wr_data_i; b = 1'b0;
    end else begin
      d = mregs[a]; b = mbusy[a];
    end
  endtask

  task automatic model_check(input string tag);
    logic [31:0] d;
    logic        b;
    for (int p = 0; p < NUM_RD; p++) begin
      model_read(rd_addr_i[p*AW +: AW], d, b);
      chk($sformatf("%s data%0d", tag, p), rd_data_o[p*XLEN +: XLEN], d);
      chk($sformatf("%s busy%0d", tag, p), {31'b0, rd_busy_o[p]}, {31'b0, b});
    end
    chk({tag, " cnt"}, {26'b0, busy_cnt_o}, model_count());
  endtask

  task automatic model_edge();
    if (wr_en_i && wr_addr_i != 0) mregs[wr_addr_i] = wr_data_i;
    if (flush_i) begin
      for (int i = 0; i < NREGS; i++) mbusy[i] = 1'b0;
    end else begin
      if (wr_en_i) mbusy[wr_addr_i] = 1'b0;
      if (alloc_en_i && alloc_addr_i != 0) mbusy[alloc_addr_i] = 1'b1;
    end
    mbusy[0] = 1'b0;
  endtask

  // Inputs driven 1 after an edge, checked 2 later, model advanced at the next edge.
  task automatic rcycle(input string tag, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic ae, input logic [4:0] aa,
                        input logic fl, input logic [4:0] r0, input logic [4:0] r1);
    drive(we, wa, wd, ae, aa, fl, r0, r1);
    #2;
    model_check(tag);
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  initial begin
    //        we  wa  wd             ae  aa  fl  r0  r1  d0             b0  d1             b1  cnt
    tbl[0]  = '{1, 5, 32'hDEAD_BEEF, 0,  0,  0,  5,  0,  32'hDEAD_BEEF, 0,  32'h0,         0,  0};
    tbl[1]  = '{0, 0, 32'h0,         0,  0,  0,  5,  5,  32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 0,  0};
    tbl[2]  = '{1, 0, 32'h1234,      0,  0,  0,  0,  5,  32'h0,         0,  32'hDEAD_BEEF, 0,  0};
    tbl[3]  = '{0, 0, 32'h0,         1,  0,  0,  0,  0,  32'h0,         0,  32'h0,         0,  0};
    tbl[4]  = '{0, 0, 32'h0,         1,  7,  0,  0,  0,  32'h0,         0,  32'h0,         0,  0};
    tbl[5]  = '{0, 0, 32'h0,         0,  0,  0,  7,  7,  32'h0,         1,  32'h0,         1,  1};
    tbl[6]  = '{1, 7, 32'h55,        0,  0,  0,  7,  5,  32'h55,        0,  32'hDEAD_BEEF, 0,  1};
    tbl[7]  = '{0, 0, 32'h0,         1,  3,  0,  7,  3,  32'h55,        0,  32'h0,         0,  0};
    tbl[8]  = '{1, 3, 32'hA5,        1,  3,  0,  3,  3,  32'hA5,        0,  32'hA5,        0,  1};
    tbl[9]  = '{0, 0, 32'h0,         0,  0,  0,  3,  7,  32'hA5,        1,  32'h55,        0,  1};
    tbl[10] = '{0, 0, 32'h0,         1,  1,  0,  1,  2,  32'h0,         0,  32'h0,         0,  1};
    tbl[11] = '{0, 0, 32'h0,         1,  2,  0,  1,  3,  32'h0,         1,  32'hA5,        1,  2};
    tbl[12] = '{0, 0, 32'h0,         1,  4,  1,  2,  4,  32'h0,         1,  32'h0,         0,  3};
    tbl[13] = '{0, 0, 32'h0,         0,  0,  0,  4,  1,  32'h0,         0,  32'h0,         0,  0};
    tbl[14] = '{1, 9, 32'hCAFE,      1,  6,  0,  9,  3,  32'hCAFE,      0,  32'hA5,        0,  0};

    rsn_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset cnt", {26'b0, busy_cnt_o}, 32'd0);
    #10 rsn_i = 1'b1;

    for (int a = 0; a < NREGS; a++) begin
      @(negedge clk_i);
      rd_addr_i = {5'(a), 5'(a)};
      #1;
      chk($sformatf("init data0 x%0d", a), rd_data_o[31:0], 32'h0);
      chk($sformatf("init data1 x%0d", a), rd_data_o[63:32], 32'h0);
      chk($sformatf("init busy x%0d", a), {30'b0, rd_busy_o}, 32'h0);
      chk("init cnt", {26'b0, busy_cnt_o}, 32'd0);
    end

    @(posedge clk_i);
    #1;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ae, tbl[i].aa, tbl[i].fl, tbl[i].r0, tbl[i].r1);
      #2;
      chk($sformatf("vec%0d data0", i), rd_data_o[31:0], tbl[i].d0);
      chk($sformatf("vec%0d busy0", i), {31'b0, rd_busy_o[0]}, {31'b0, tbl[i].b0});
      chk($sformatf("vec%0d data1", i), rd_data_o[63:32], tbl[i].d1);
      chk($sformatf("vec%0d busy1", i), {31'b0, rd_busy_o[1]}, {31'b0, tbl[i].b1});
      chk($sformatf("vec%0d cnt", i), {26'b0, busy_cnt_o}, tbl[i].cnt);
      @(posedge clk_i);
      #1;
    end

    // x9 written and x6 allocated by the last vector; reset mid-cycle must clear both at once.
    drive(0, 0, 0, 0, 0, 0, 9, 6);
    #1;
    chk("pre-rst x9", rd_data_o[31:0], 32'hCAFE);
    chk("pre-rst x6 busy", {31'b0, rd_busy_o[1]}, 32'd1);
    chk("pre-rst cnt", {26'b0, busy_cnt_o}, 32'd1);
    #1 rsn_i = 1'b0;
    #1;
    chk("mid-rst x9", rd_data_o[31:0], 32'h0);
    chk("mid-rst x6 busy", {31'b0, rd_busy_o[1]}, 32'd0);
    chk("mid-rst cnt", {26'b0, busy_cnt_o}, 32'd0);
    #1 rsn_i = 1'b1;
    model_clear();
    @(posedge clk_i);
    #1;

    // Fill every allocatable register, re-alloc a busy one, then writeback one.
    for (int r = 0; r < NREGS; r++) rcycle("fill", 0, 0, 0, 1, 5'(r), 0, 5'(r), 5'(r + 1));
    rcycle("realloc", 0, 0, 0, 1, 5'd5, 0, 5'd5, 5'd31);
    rcycle("full", 1, 5'd5, 32'h77, 0, 0, 0, 5'd5, 5'd0);
    rcycle("one-wb", 0, 0, 0, 0, 0, 0, 5'd5, 5'd6);
    chk("full cnt", {26'b0, busy_cnt_o}, 32'd30);
    rcycle("flush+wr", 1, 5'd6, 32'h66, 1, 5'd6, 1, 5'd6, 5'd7);
    rcycle("post-flush", 0, 0, 0, 0, 0, 0, 5'd6, 5'd7);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, aa, r0, r1;
      logic       we, ae, fl;
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      aa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? aa : 5'($urandom);
      we = ($urandom_range(0, 1) == 1);
      ae = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 19) == 0);
      rcycle("rand", we, wa, $urandom, ae, aa, fl, r0, r1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
